// File: rtl/jtag_dr_engine.sv
// jtag_dr_engine: TCK-domain DR back end; registered outputs, tdo is sr[0]; no backpressure, toggles signal requests.
// Latency: capture/shift/update each act on one tck posedge. Optional macro JTAG_ADDR_AUTOINC_EN adds post-access address increment.
// Backpressure: none; the system side must consume a toggle before the next update of the same kind.

`ifndef IR_LENGTH
`define IR_LENGTH 4
`endif
`ifndef IIDENT
`define IIDENT 4'h1
`endif
`ifndef IRADDR
`define IRADDR 4'h2
`endif
`ifndef IWADDR
`define IWADDR 4'h3
`endif
`ifndef IWDATA
`define IWDATA 4'h4
`endif
`ifndef IRDATA
`define IRDATA 4'h5
`endif

module jtag_dr_engine #(
    parameter int          IR_W   = `IR_LENGTH,
    parameter int          ADDR_W = 16,
    parameter int          DATA_W = 32,
    parameter logic [31:0] IDCODE = 32'h4A544731
) (
    input  logic              tck,
    input  logic              reset_n,
    input  logic              tdi,
    output logic              tdo,
    input  logic [IR_W-1:0]   ir,
    input  logic              capture_dr,
    input  logic              shift_dr,
    input  logic              update_dr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_tog,
    output logic              rd_tog,
    output logic              len_err
);

    localparam int MAX_AD = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int SR_W   = (MAX_AD > 32) ? MAX_AD : 32;
    localparam int CNT_W  = $clog2(SR_W + 2);

    localparam logic [IR_W-1:0] IR_IDENT = IR_W'(`IIDENT);
    localparam logic [IR_W-1:0] IR_RADDR = IR_W'(`IRADDR);
    localparam logic [IR_W-1:0] IR_WADDR = IR_W'(`IWADDR);
    localparam logic [IR_W-1:0] IR_WDATA = IR_W'(`IWDATA);
    localparam logic [IR_W-1:0] IR_RDATA = IR_W'(`IRDATA);

    logic [SR_W-1:0]  sr;
    logic [SR_W-1:0]  sr_up;
    logic [SR_W-1:0]  sr_shift;
    logic [SR_W-1:0]  cap_val;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] len_m1;
    logic             upd_done;

    assign tdo = sr[0];

    always_comb begin
        len     = CNT_W'(1);
        cap_val = '0;
        case (ir)
            IR_IDENT: begin len = CNT_W'(32);     cap_val = SR_W'(IDCODE);  end
            IR_RADDR: begin len = CNT_W'(ADDR_W); cap_val = SR_W'(rd_addr); end
            IR_WADDR: begin len = CNT_W'(ADDR_W); cap_val = SR_W'(wr_addr); end
            IR_WDATA: begin len = CNT_W'(DATA_W); cap_val = SR_W'(wr_data); end
            IR_RDATA: begin len = CNT_W'(DATA_W); cap_val = SR_W'(rd_data); end
            default:  begin len = CNT_W'(1);      cap_val = '0;             end
        endcase
    end

    // Only the low L bits move; tdi enters at bit L-1 and bits above L are held.
    always_comb begin
        len_m1   = len - CNT_W'(1);
        sr_up    = sr >> 1;
        sr_shift = sr;
        for (int i = 0; i < SR_W; i++) begin
            if (CNT_W'(i) < len_m1)
                sr_shift[i] = sr_up[i];
            else if (CNT_W'(i) == len_m1)
                sr_shift[i] = tdi;
        end
    end

    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            sr       <= '0;
            cnt      <= '0;
            upd_done <= 1'b0;
            rd_addr  <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_tog   <= 1'b0;
            rd_tog   <= 1'b0;
            len_err  <= 1'b0;
        end else if (capture_dr) begin
            sr       <= cap_val;
            cnt      <= '0;
            upd_done <= 1'b0;
        end else if (shift_dr) begin
            sr <= sr_shift;
            if (cnt <= len)
                cnt <= cnt + CNT_W'(1);
        end else if (update_dr && !upd_done) begin
            // A held update acts once; only a new capture re-arms it.
            upd_done <= 1'b1;
            if (cnt != len) begin
                len_err <= 1'b1;
            end else begin
                case (ir)
                    IR_RADDR: begin
                        rd_addr <= sr[ADDR_W-1:0];
                        rd_tog  <= ~rd_tog;
                    end
                    IR_WADDR: wr_addr <= sr[ADDR_W-1:0];
                    IR_WDATA: begin
                        wr_data <= sr[DATA_W-1:0];
                        wr_tog  <= ~wr_tog;
`ifdef JTAG_ADDR_AUTOINC_EN
                        wr_addr <= wr_addr + ADDR_W'(1);
`endif
                    end
                    IR_RDATA: begin
                        rd_tog  <= ~rd_tog;
`ifdef JTAG_ADDR_AUTOINC_EN
                        rd_addr <= rd_addr + ADDR_W'(1);
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtag_dr_engine.sv
// Bench for jtag_dr_engine: a register-as-bit-queue model checked every cycle, plus literal scan results.

`ifndef IIDENT
`define IIDENT 4'h1
`endif
`ifndef IRADDR
`define IRADDR 4'h2
`endif
`ifndef IWADDR
`define IWADDR 4'h3
`endif
`ifndef IWDATA
`define IWDATA 4'h4
`endif
`ifndef IRDATA
`define IRDATA 4'h5
`endif

module tb_jtag_dr_engine;

    localparam logic [3:0] C_IDENT = 4'(`IIDENT);
    localparam logic [3:0] C_RADDR = 4'(`IRADDR);
    localparam logic [3:0] C_WADDR = 4'(`IWADDR);
    localparam logic [3:0] C_WDATA = 4'(`IWDATA);
    localparam logic [3:0] C_RDATA = 4'(`IRDATA);
    localparam logic [3:0] C_BYP   = 4'hF;
`ifdef JTAG_ADDR_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic        tck = 1'b0;
    logic        reset_n;
    logic        tdi;
    logic        tdo;
    logic [3:0]  ir;
    logic        capture_dr, shift_dr, update_dr;
    logic [31:0] rd_data;
    logic [15:0] rd_addr, wr_addr;
    logic [31:0] wr_data;
    logic        wr_tog, rd_tog, len_err;

    jtag_dr_engine #(.IR_W(4), .ADDR_W(16), .DATA_W(32), .IDCODE(32'h4A544731)) dut (
        .tck(tck), .reset_n(reset_n), .tdi(tdi), .tdo(tdo), .ir(ir),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
        .rd_data(rd_data), .rd_addr(rd_addr), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_tog(wr_tog), .rd_tog(rd_tog), .len_err(len_err)
    );

    always #5 tck = ~tck;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the selected data register is a queue of L bits, head = tdo.
    logic        q[$];
    int          m_cnt;
    bit          m_done;
    logic [15:0] m_rd_addr, m_wr_addr;
    logic [31:0] m_wr_data;
    logic        m_wt, m_rt, m_le;

    function automatic int len_of(input logic [3:0] code);
        if (code == C_IDENT) return 32;
        if (code == C_RADDR || code == C_WADDR) return 16;
        if (code == C_WDATA || code == C_RDATA) return 32;
        return 1;
    endfunction

    task automatic model_reset();
        q.delete();
        q.push_back(1'b0);
        m_cnt = 0; m_done = 0;
        m_rd_addr = '0; m_wr_addr = '0; m_wr_data = '0;
        m_wt = 0; m_rt = 0; m_le = 0;
    endtask

    task automatic model_edge();
        int          l;
        logic [63:0] v;
        l = len_of(ir);
        if (!reset_n) return;
        if (capture_dr) begin
            if (ir == C_IDENT)      v = 64'h4A544731;
            else if (ir == C_RADDR) v = 64'(m_rd_addr);
            else if (ir == C_WADDR) v = 64'(m_wr_addr);
            else if (ir == C_WDATA) v = 64'(m_wr_data);
            else if (ir == C_RDATA) v = 64'(rd_data);
            else                    v = 64'd0;
            q.delete();
            for (int i = 0; i < l; i++) q.push_back(v[i]);
            m_cnt = 0; m_done = 0;
        end else if (shift_dr) begin
            if (q.size() > 0) void'(q.pop_front());
            q.push_back(tdi);
            if (m_cnt < l + 1) m_cnt++;
        end else if (update_dr && !m_done) begin
            m_done = 1;
            if (m_cnt != l) begin
                m_le = 1;
            end else begin
                v = '0;
                for (int i = 0; i < q.size() && i < 64; i++) v[i] = q[i];
                if (ir == C_RADDR) begin
                    m_rd_addr = v[15:0]; m_rt = ~m_rt;
                end else if (ir == C_WADDR) begin
                    m_wr_addr = v[15:0];
                end else if (ir == C_WDATA) begin
                    m_wr_data = v[31:0]; m_wt = ~m_wt;
                    if (AUTOINC) m_wr_addr = m_wr_addr + 16'd1;
                end else if (ir == C_RDATA) begin
                    m_rt = ~m_rt;
                    if (AUTOINC) m_rd_addr = m_rd_addr + 16'd1;
                end
            end
        end
    endtask

    always @(negedge tck) begin
        if (chk_en) begin
            check("tdo",     64'(tdo),     64'((q.size() > 0) ? q[0] : 1'b0));
            check("rd_addr", 64'(rd_addr), 64'(m_rd_addr));
            check("wr_addr", 64'(wr_addr), 64'(m_wr_addr));
            check("wr_data", 64'(wr_data), 64'(m_wr_data));
            check("wr_tog",  64'(wr_tog),  64'(m_wt));
            check("rd_tog",  64'(rd_tog),  64'(m_rt));
            check("len_err", 64'(len_err), 64'(m_le));
        end
    end

    task automatic cyc(input logic c, input logic s, input logic u, input logic t, output logic tdo_s);
        @(negedge tck);
        tdo_s      = tdo;
        capture_dr = c; shift_dr = s; update_dr = u; tdi = t;
        @(posedge tck);
        model_edge();
    endtask

    task automatic scan(input logic [3:0] code, input logic [63:0] din, input int n,
                        input int nupd, output logic [63:0] dout);
        logic s;
        ir   = code;
        dout = '0;
        cyc(1, 0, 0, 0, s);
        for (int i = 0; i < n; i++) begin
            cyc(0, 1, 0, din[i % 64], s);
            if (i < 64) dout[i] = s;
        end
        for (int k = 0; k < nupd; k++) cyc(0, 0, 1, 0, s);
        cyc(0, 0, 0, 0, s);
        @(negedge tck);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        logic        s;
        reset_n = 1'b0; ir = 4'h0; tdi = 1'b0;
        capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0; rd_data = '0;
        model_reset();
        repeat (3) @(negedge tck);
        check("rst_tdo",     64'(tdo),     64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_togs",    64'({wr_tog, rd_tog, len_err}), 64'd0);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        scan(C_IDENT, 64'd0, 32, 1, d);
        check("idcode_stream", d[31:0], 64'h4A544731);
        check("ident_no_effect", 64'({wr_tog, rd_tog, len_err}), 64'd0);

        scan(C_WADDR, 64'h0005, 16, 1, d);
        check("waddr_5", 64'(wr_addr), 64'h0005);
        scan(C_WDATA, 64'hDEADBEEF, 32, 1, d);
        check("wdata_beef", 64'(wr_data), 64'hDEADBEEF);
        check("wr_tog_1", 64'(wr_tog), 64'd1);
        check("waddr_post", 64'(wr_addr), AUTOINC ? 64'h0006 : 64'h0005);

        scan(C_RADDR, 64'h00A5, 16, 3, d);
        check("raddr_a5", 64'(rd_addr), 64'h00A5);
        check("rd_tog_held_upd", 64'(rd_tog), 64'd1);
        rd_data = 32'h12345678;
        scan(C_RDATA, 64'd0, 32, 1, d);
        check("rdata_stream", d[31:0], 64'h12345678);
        check("raddr_post", 64'(rd_addr), AUTOINC ? 64'h00A6 : 64'h00A5);
        check("rd_tog_0", 64'(rd_tog), 64'd0);

        scan(C_BYP, 64'h1, 1, 1, d);
        check("bypass_capture", d[0], 64'd0);
        check("bypass_no_err", 64'(len_err), 64'd0);

        scan(C_WADDR, 64'hFFFF, 16, 1, d);
        check("waddr_capture", d[15:0], AUTOINC ? 64'h0006 : 64'h0005);
        scan(C_WDATA, 64'h0BADF00D, 32, 1, d);
        check("waddr_wrap", 64'(wr_addr), AUTOINC ? 64'h0000 : 64'hFFFF);
        check("wr_tog_0", 64'(wr_tog), 64'd0);
        check("wdata_capture", d[31:0], 64'hDEADBEEF);

        scan(C_WDATA, 64'h11111111, 20, 1, d);
        check("lenerr_wdata_kept", 64'(wr_data), 64'h0BADF00D);
        check("lenerr_tog_kept", 64'(wr_tog), 64'd0);
        check("lenerr_set", 64'(len_err), 64'd1);
        scan(C_WDATA, 64'hCAFEF00D, 32, 1, d);
        check("good_after_err", 64'(wr_data), 64'hCAFEF00D);
        check("lenerr_sticky", 64'(len_err), 64'd1);

        // Asynchronous reset in the middle of a data shift.
        ir = C_WDATA;
        cyc(1, 0, 0, 0, s);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 1'b1, s);
        @(negedge tck);
        capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_data", 64'({wr_addr, rd_addr}), 64'd0);
        check("async_rst_wdata", 64'(wr_data), 64'd0);
        check("async_rst_flags", 64'({tdo, wr_tog, rd_tog, len_err}), 64'd0);
        repeat (2) @(negedge tck);
        reset_n = 1'b1;
        cyc(0, 0, 1, 0, s);
        cyc(0, 0, 0, 0, s);
        @(negedge tck);
        check("upd_only_len_err", 64'(len_err), 64'd1);
        check("upd_only_no_tog", 64'({wr_tog, rd_tog}), 64'd0);
        check("upd_only_wdata", 64'(wr_data), 64'd0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
